// File: rtl/rom_loader.sv
// Loads a record-structured byte stream into the even/odd program ROM banks.
// Each record carries an address, a length, data bytes and a checksum; the image ends with a LEN==0 record.
module rom_loader #(
  parameter int unsigned SIZE    = 2048,
  parameter logic [15:0] ROMBASE = 16'h4000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [14:0] write_addr_even,
  output logic [7:0]  write_data_even,
  output logic        write_en_even,
  output logic [14:0] write_addr_odd,
  output logic [7:0]  write_data_odd,
  output logic        write_en_odd,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error,
  output logic [15:0] bytes_written
);

  typedef enum logic [2:0] {
    S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] SIZE_W = 17'(SIZE);

  state_t      state;
  logic [15:0] addr;
  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  sum;
  logic        accept;
  logic [15:0] cpu_addr;
  logic [15:0] index;
  logic [7:0]  sum_next;

  assign in_ready = (state != S_DONE) && (state != S_ERROR);
  assign busy     = in_ready && (state != S_ADDR_HI);
  assign accept   = in_valid && in_ready;
  assign cpu_addr = addr + idx;
  assign index    = cpu_addr - ROMBASE;
  assign sum_next = sum + in_data;

  always_ff @(posedge clk) begin
    write_en_even <= 1'b0;
    write_en_odd  <= 1'b0;
    if (!reset_n || clear) begin
      state           <= S_ADDR_HI;
      addr            <= '0;
      len             <= '0;
      idx             <= '0;
      sum             <= '0;
      write_addr_even <= '0;
      write_data_even <= '0;
      write_addr_odd  <= '0;
      write_data_odd  <= '0;
      done            <= 1'b0;
      error           <= '0;
      bytes_written   <= '0;
    end else if (accept) begin
      sum <= sum_next;
      case (state)
        S_ADDR_HI: begin
          addr[15:8] <= in_data;
          state      <= S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr[7:0] <= in_data;
          state     <= S_LEN_HI;
        end
        S_LEN_HI: begin
          len[15:8] <= in_data;
          state     <= S_LEN_LO;
        end
        S_LEN_LO: begin
          len[7:0] <= in_data;
          idx      <= '0;
          state    <= ({len[15:8], in_data} == 16'h0000) ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          // Out-of-range byte is consumed but not written; the record is abandoned here.
          if ({1'b0, index} >= SIZE_W) begin
            error <= 2'd2;
            state <= S_ERROR;
          end else begin
            if (cpu_addr[0]) begin
              write_addr_odd <= cpu_addr[15:1];
              write_data_odd <= in_data;
              write_en_odd   <= 1'b1;
            end else begin
              write_addr_even <= cpu_addr[15:1];
              write_data_even <= in_data;
              write_en_even   <= 1'b1;
            end
            bytes_written <= bytes_written + 16'd1;
            idx           <= idx + 16'd1;
            if (idx + 16'd1 == len) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          sum <= '0;
          if (sum_next != 8'h00) begin
            error <= 2'd1;
            state <= S_ERROR;
          end else if (len == 16'h0000) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_ADDR_HI;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: record loads, bank steering, checksum/range errors, clear and reset.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] write_addr_even;
  logic [7:0]  write_data_even;
  logic        write_en_even;
  logic [14:0] write_addr_odd;
  logic [7:0]  write_data_odd;
  logic        write_en_odd;
  logic        busy;
  logic        done;
  logic [1:0]  error;
  logic [15:0] bytes_written;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned both_cnt = 0;
  logic [23:0] wlog[$];

  rom_loader #(.SIZE(2048), .ROMBASE(16'h4000)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .write_addr_even(write_addr_even), .write_data_even(write_data_even),
    .write_en_even(write_en_even),
    .write_addr_odd(write_addr_odd), .write_data_odd(write_data_odd),
    .write_en_odd(write_en_odd),
    .busy(busy), .done(done), .error(error), .bytes_written(bytes_written)
  );

  always #5 clk = ~clk;

  // Strobe log entry: {bank(1=odd), word address, data}.
  always @(negedge clk) begin
    if (write_en_even && write_en_odd) both_cnt++;
    if (write_en_even) wlog.push_back({1'b0, write_addr_even, write_data_even});
    if (write_en_odd)  wlog.push_back({1'b1, write_addr_odd, write_data_odd});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned k);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic end_rec();
    repeat (5) send_byte(8'h00);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    wlog.delete();
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {30'b0, error}, 32'd0);
    check("rst_bytes", {16'b0, bytes_written}, 32'd0);
    check("rst_strobes", {30'b0, write_en_even, write_en_odd}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    wlog.delete();

    // Even-aligned record, checksum 0x59 makes the 8-bit sum zero.
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    check("t1_busy", {31'b0, busy}, 32'd1);
    send_byte(8'hAA);
    check("t1_en_even", {30'b0, write_en_even, write_en_odd}, 32'd2);
    check("t1_addr_even", {17'b0, write_addr_even}, 32'h2000);
    check("t1_data_even", {24'b0, write_data_even}, 32'hAA);
    send_byte(8'hBB);
    check("t1_en_odd", {30'b0, write_en_even, write_en_odd}, 32'd1);
    check("t1_addr_odd", {17'b0, write_addr_odd}, 32'h2000);
    check("t1_data_odd", {24'b0, write_data_odd}, 32'hBB);
    send_byte(8'h59);
    check("t1_strobe_one_cycle", {30'b0, write_en_even, write_en_odd}, 32'd0);
    check("t1_hold_addr_odd", {17'b0, write_addr_odd}, 32'h2000);
    end_rec();
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_error", {30'b0, error}, 32'd0);
    check("t1_bytes", {16'b0, bytes_written}, 32'd2);
    check("t1_ready", {31'b0, in_ready}, 32'd0);
    check("t1_busy_done", {31'b0, busy}, 32'd0);

    // Odd start address, checksum 0x8A.
    pulse_clear();
    check("t2_clr_done", {31'b0, done}, 32'd0);
    check("t2_clr_bytes", {16'b0, bytes_written}, 32'd0);
    send_byte(8'h40); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11);
    check("t2_en_odd", {30'b0, write_en_even, write_en_odd}, 32'd1);
    check("t2_addr_odd", {17'b0, write_addr_odd}, 32'h2000);
    check("t2_data_odd", {24'b0, write_data_odd}, 32'h11);
    send_byte(8'h22);
    check("t2_en_even", {30'b0, write_en_even, write_en_odd}, 32'd2);
    check("t2_addr_even", {17'b0, write_addr_even}, 32'h2001);
    check("t2_data_even", {24'b0, write_data_even}, 32'h22);
    send_byte(8'h8A);
    end_rec();
    check("t2_done", {31'b0, done}, 32'd1);
    check("t2_bytes", {16'b0, bytes_written}, 32'd2);

    // Bad checksum: writes stay issued, error=1.
    pulse_clear();
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h58);
    idle(2);
    check("t3_error", {30'b0, error}, 32'd1);
    check("t3_done", {31'b0, done}, 32'd0);
    check("t3_ready", {31'b0, in_ready}, 32'd0);
    check("t3_log_n", wlog.size(), 32'd2);
    check("t3_log0", {8'b0, wlog[0]}, {8'b0, 1'b0, 15'h2000, 8'hAA});
    check("t3_log1", {8'b0, wlog[1]}, {8'b0, 1'b1, 15'h2000, 8'hBB});
    pulse_clear();
    check("t3_clr_error", {30'b0, error}, 32'd0);
    check("t3_clr_ready", {31'b0, in_ready}, 32'd1);

    // Range boundary: 47FF is the last byte, 4800 is out of range.
    send_byte(8'h47); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hC3);
    check("t4_en_odd", {30'b0, write_en_even, write_en_odd}, 32'd1);
    check("t4_addr_odd", {17'b0, write_addr_odd}, 32'h23FF);
    check("t4_data_odd", {24'b0, write_data_odd}, 32'hC3);
    send_byte(8'h5A);
    check("t4_no_strobe", {30'b0, write_en_even, write_en_odd}, 32'd0);
    check("t4_error", {30'b0, error}, 32'd2);
    check("t4_ready", {31'b0, in_ready}, 32'd0);
    check("t4_busy", {31'b0, busy}, 32'd0);
    check("t4_bytes", {16'b0, bytes_written}, 32'd1);
    idle(3);
    check("t4_log_n", wlog.size(), 32'd1);

    // Gappy stream, then reset in the middle of the data phase.
    pulse_clear();
    send_byte(8'h40); idle($urandom_range(0, 2));
    send_byte(8'h10); idle($urandom_range(0, 2));
    send_byte(8'h00); idle($urandom_range(0, 2));
    send_byte(8'h06);
    for (int i = 1; i <= 4; i++) begin
      idle($urandom_range(0, 3));
      send_byte(8'(i));
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("t5_log_n", wlog.size(), 32'd4);
    check("t5_log0", {8'b0, wlog[0]}, {8'b0, 1'b0, 15'h2008, 8'h01});
    check("t5_log1", {8'b0, wlog[1]}, {8'b0, 1'b1, 15'h2008, 8'h02});
    check("t5_log2", {8'b0, wlog[2]}, {8'b0, 1'b0, 15'h2009, 8'h03});
    check("t5_log3", {8'b0, wlog[3]}, {8'b0, 1'b1, 15'h2009, 8'h04});
    check("t5_rst_ready", {31'b0, in_ready}, 32'd1);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    check("t5_rst_bytes", {16'b0, bytes_written}, 32'd0);
    check("t5_rst_addr_even", {17'b0, write_addr_even}, 32'd0);
    check("t5_rst_data_odd", {24'b0, write_data_odd}, 32'd0);
    check("t5_rst_strobes", {30'b0, write_en_even, write_en_odd}, 32'd0);
    reset_n = 1'b1;
    wlog.delete();
    // 40+20+01+77 = D8, checksum 0x28.
    send_byte(8'h40); send_byte(8'h20); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h77); send_byte(8'h28);
    end_rec();
    check("t5_done", {31'b0, done}, 32'd1);
    check("t5_bytes", {16'b0, bytes_written}, 32'd1);
    check("t5_log_n2", wlog.size(), 32'd1);
    check("t5_new", {8'b0, wlog[0]}, {8'b0, 1'b0, 15'h2010, 8'h77});

    check("no_dual_strobe", both_cnt, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
